// File: rtl/fp_pkg.sv
// Shared floating-point types and constants for the FPU datapath blocks.
package fp_pkg;

  localparam int FP_EXP_BITS = 8;
  localparam int FP_SIG_BITS = 23;
  localparam int FP_BIAS     = (2 ** (FP_EXP_BITS - 1)) - 1;

  localparam logic [FP_EXP_BITS+FP_SIG_BITS:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_NAN,
    ERR_INF,
    ERR_ZERO,
    ERR_DENORM
  } o_err_t;

  // Only bit 0 of the opcode reaches the adder/subtractor.
  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } opcode_t;

endpackage

// File: rtl/fp_add_sub_if.sv
// Operand/result bundle of the FP adder/subtractor; the requester is master.
interface fp_add_sub_if
  import fp_pkg::*;
#(
  parameter int EXP_BITS = FP_EXP_BITS,
  parameter int SIG_BITS = FP_SIG_BITS
);

  logic                       sign1;
  logic [EXP_BITS-1:0]        exp1;
  logic [SIG_BITS-1:0]        sig1;
  logic                       sign2;
  logic [EXP_BITS-1:0]        exp2;
  logic [SIG_BITS-1:0]        sig2;
  logic                       opcode;
  logic [EXP_BITS+SIG_BITS:0] fp_out;
  o_err_t                     err_o;

  modport master (
    output sign1, exp1, sig1, sign2, exp2, sig2, opcode,
    input  fp_out, err_o
  );

  modport slave (
    input  sign1, exp1, sig1, sign2, exp2, sig2, opcode,
    output fp_out, err_o
  );

endinterface

// File: rtl/fp_lzc.sv
// Parameterised leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
  parameter int WIDTH = 27,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count
);

  // Scanning upward lets the highest set bit win.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fp_add_sub.sv
// IEEE-754 adder/subtractor, round-to-nearest-even, one registered stage.
// Optional FP_ADD_FTZ_EN: denormal inputs read as zero, tiny results flush to zero.
module fp_add_sub
  import fp_pkg::*;
#(
  parameter int EXP_BITS = FP_EXP_BITS,
  parameter int SIG_BITS = FP_SIG_BITS
) (
  input logic         clk,
  input logic         rstn,
  fp_add_sub_if.slave bus
);

  localparam int M   = SIG_BITS + 4;
  localparam int EW  = EXP_BITS + 2;
  localparam int LZW = $clog2(M + 1);
  localparam int MW  = SIG_BITS + 2;
  localparam int FW  = EXP_BITS + SIG_BITS + 1;

  localparam logic [EXP_BITS-1:0] EXP_MAX = '1;
  localparam logic [FW-1:0]       QNAN_W  = {1'b0, EXP_MAX, 1'b1, {(SIG_BITS-1){1'b0}}};

  logic                sign2_eff;
  logic                nan1, nan2, inf1, inf2;
  logic [SIG_BITS-1:0] frac1, frac2;
  logic [EXP_BITS-1:0] e1, e2, ea, eb, diff;
  logic [SIG_BITS:0]   m1, m2, ma, mb;
  logic                sa, sb;
  logic [M-1:0]        mb_ext, mb_al;
  logic [M:0]          sum;
  logic [LZW-1:0]      lz;

  logic [EW-1:0]       sh, e_norm, e_field;
  logic [M-1:0]        norm;
  logic                rnd_up;
  logic [MW-1:0]       mant_r;
  logic [SIG_BITS-1:0] frac_r;
  logic                res_sign;
  logic [FW-1:0]       result;
  o_err_t              result_err;

  // Unpack, order by magnitude, align the smaller operand and add/subtract.
  always_comb begin
    sign2_eff = bus.sign2 ^ bus.opcode;
    nan1 = (bus.exp1 == EXP_MAX) && (bus.sig1 != '0);
    nan2 = (bus.exp2 == EXP_MAX) && (bus.sig2 != '0);
    inf1 = (bus.exp1 == EXP_MAX) && (bus.sig1 == '0);
    inf2 = (bus.exp2 == EXP_MAX) && (bus.sig2 == '0);
`ifdef FP_ADD_FTZ_EN
    frac1 = (bus.exp1 == '0) ? '0 : bus.sig1;
    frac2 = (bus.exp2 == '0) ? '0 : bus.sig2;
`else
    frac1 = bus.sig1;
    frac2 = bus.sig2;
`endif
    e1 = (bus.exp1 == '0) ? EXP_BITS'(1) : bus.exp1;
    e2 = (bus.exp2 == '0) ? EXP_BITS'(1) : bus.exp2;
    m1 = {bus.exp1 != '0, frac1};
    m2 = {bus.exp2 != '0, frac2};

    if ({bus.exp2, frac2} > {bus.exp1, frac1}) begin
      ea = e2; ma = m2; sa = sign2_eff;
      eb = e1; mb = m1; sb = bus.sign1;
    end else begin
      ea = e1; ma = m1; sa = bus.sign1;
      eb = e2; mb = m2; sb = sign2_eff;
    end

    diff   = ea - eb;
    mb_ext = {mb, 3'b000};
    if ({2'b00, diff} >= EW'(SIG_BITS + 3)) begin
      mb_al = {{(M-1){1'b0}}, |mb};
    end else begin
      mb_al    = mb_ext >> diff;
      mb_al[0] = mb_al[0] | (|(mb_ext & ((M'(1) << diff) - M'(1))));
    end

    if (sa ^ sb) sum = {1'b0, ma, 3'b000} - {1'b0, mb_al};
    else         sum = {1'b0, ma, 3'b000} + {1'b0, mb_al};
  end

  fp_lzc #(.WIDTH(M)) u_lzc (
    .data  (sum[M-1:0]),
    .count (lz)
  );

  // Normalise, round to nearest even, then apply the special-case priority.
  always_comb begin
    sh = '0;
    if (sum[M]) begin
      norm   = {sum[M:2], sum[1] | sum[0]};
      e_norm = {2'b00, ea} + EW'(1);
    end else begin
      // Left shift stops once the exponent reaches 1 (gradual underflow).
      sh     = (EW'(lz) > ({2'b00, ea} - EW'(1))) ? ({2'b00, ea} - EW'(1)) : EW'(lz);
      norm   = sum[M-1:0] << sh;
      e_norm = {2'b00, ea} - sh;
    end

    e_field = norm[M-1] ? e_norm : '0;
    rnd_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant_r  = {1'b0, norm[M-1:3]} + MW'(rnd_up);

    if (mant_r[MW-1]) begin
      e_field = e_field + EW'(1);
      frac_r  = mant_r[SIG_BITS:1];
    end else begin
      if (mant_r[SIG_BITS] && (e_field == '0)) e_field = EW'(1);
      frac_r = mant_r[SIG_BITS-1:0];
    end

    res_sign = (sum == '0) ? (sa & sb) : sa;

    if (nan1 || nan2 || (inf1 && inf2 && (bus.sign1 ^ sign2_eff))) begin
      result = QNAN_W;
    end else if (inf1) begin
      result = {bus.sign1, EXP_MAX, {SIG_BITS{1'b0}}};
    end else if (inf2) begin
      result = {sign2_eff, EXP_MAX, {SIG_BITS{1'b0}}};
    end else if (e_field >= {2'b00, EXP_MAX}) begin
      result = {res_sign, EXP_MAX, {SIG_BITS{1'b0}}};
    end else begin
      result = {res_sign, e_field[EXP_BITS-1:0], frac_r};
`ifdef FP_ADD_FTZ_EN
      if (e_field == '0) result = {res_sign, {(FW-1){1'b0}}};
`endif
    end
  end

  always_comb begin
    if (result[FW-2:SIG_BITS] == EXP_MAX) begin
      result_err = (result[SIG_BITS-1:0] != '0) ? ERR_NAN : ERR_INF;
    end else if (result[FW-2:SIG_BITS] == '0) begin
      result_err = (result[SIG_BITS-1:0] == '0) ? ERR_ZERO : ERR_DENORM;
    end else begin
      result_err = ERR_NONE;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.fp_out <= '0;
      bus.err_o  <= ERR_NONE;
    end else begin
      bus.fp_out <= result;
      bus.err_o  <= result_err;
    end
  end

endmodule

// File: tb/tb_fp_add_sub.sv
// Self-checking bench for fp_add_sub: directed cases plus randomised operands
// checked against an exact-arithmetic rounding model.
module tb_fp_add_sub;
  import fp_pkg::*;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  fp_add_sub_if bus ();

  fp_add_sub dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic o_err_t classify(input logic [31:0] v);
    if (v[30:23] == 8'hFF) return (v[22:0] != 0) ? ERR_NAN : ERR_INF;
    if (v[30:23] == 8'h00) return (v[22:0] == 0) ? ERR_ZERO : ERR_DENORM;
    return ERR_NONE;
  endfunction

  // Exact sum on wide integers, then a single round-to-nearest-even.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic         sa, sb, sign;
    logic         nan_a, nan_b, inf_a, inf_b;
    int           ea, eb, emin, p, shift, field;
    logic [319:0] ma, mb, mag, q, rem, half;
    logic [31:0]  res;
    sa    = a[31];
    sb    = b[31] ^ sub;
    nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) return QNAN;
    if (inf_a) return {sa, 8'hFF, 23'h0};
    if (inf_b) return {sb, 8'hFF, 23'h0};
    ea = (a[30:23] == 0) ? 1 : int'(a[30:23]);
    eb = (b[30:23] == 0) ? 1 : int'(b[30:23]);
    ma = 320'({a[30:23] != 0, a[22:0]});
    mb = 320'({b[30:23] != 0, b[22:0]});
`ifdef FP_ADD_FTZ_EN
    if (a[30:23] == 0) ma = '0;
    if (b[30:23] == 0) mb = '0;
`endif
    emin = (ea < eb) ? ea : eb;
    ma   = ma << (ea - emin);
    mb   = mb << (eb - emin);
    sign = 1'b0;
    if (sa == sb) begin
      mag = ma + mb; sign = sa;
    end else if (ma > mb) begin
      mag = ma - mb; sign = sa;
    end else begin
      mag = mb - ma; sign = sb;
    end
    if (mag == 0) return {(sa == sb) ? sa : 1'b0, 31'h0};
    p = 0;
    for (int i = 0; i < 320; i++) if (mag[i]) p = i;
    shift = p - 23;
    if (shift < 1 - emin) shift = 1 - emin;
    if (shift <= 0) begin
      q = mag << (-shift);
    end else begin
      q    = mag >> shift;
      rem  = mag & ((320'd1 << shift) - 320'd1);
      half = 320'd1 << (shift - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 320'd1;
    end
    if (q[24]) begin
      q = q >> 1;
      shift++;
    end
    if (q[23]) begin
      field = shift + emin;
      if (field >= 255) res = {sign, 8'hFF, 23'h0};
      else              res = {sign, 8'(field), q[22:0]};
    end else begin
`ifdef FP_ADD_FTZ_EN
      res = {sign, 31'h0};
`else
      res = {sign, 8'h00, q[22:0]};
`endif
    end
    return res;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 15))
      0: begin v[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) v[22:0] = '0; end
      1: v[30:23] = 8'h00;
      2: v[30:0]  = '0;
      3: v[30:23] = 8'hFE;
      default: ;
    endcase
    return v;
  endfunction

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic op);
    @(negedge clk);
    bus.sign1  = a[31];
    bus.exp1   = a[30:23];
    bus.sig1   = a[22:0];
    bus.sign2  = b[31];
    bus.exp2   = b[30:23];
    bus.sig2   = b[22:0];
    bus.opcode = op;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] exp_val, input o_err_t exp_err);
    checks++;
    assert (bus.fp_out === exp_val) else begin
      errors++;
      $error("[TB] FAIL %s fp_out observed %h expected %h", tag, bus.fp_out, exp_val);
    end
    checks++;
    assert (bus.err_o === exp_err) else begin
      errors++;
      $error("[TB] FAIL %s err_o observed %s expected %s", tag, bus.err_o.name(), exp_err.name());
    end
  endtask

  task automatic runCase(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic op, input logic [31:0] exp_val, input o_err_t exp_err);
    applyStimulus(a, b, op);
    @(posedge clk);
    #1;
    checkOutput(tag, exp_val, exp_err);
  endtask

  initial begin
    logic [31:0] ra, rb, rexp;
    logic        rop;
    int          e;
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    applyStimulus(32'h3F80_0000, 32'h4000_0000, 1'b0);
    #1;
    checkOutput("reset_state", 32'h0, ERR_NONE);

    @(negedge clk);
    rstn = 1'b1;
    #1;
    checkOutput("hold_after_release", 32'h0, ERR_NONE);
    @(posedge clk);
    #1;
    checkOutput("add_1_2", 32'h4040_0000, ERR_NONE);

    runCase("sub_equal",     32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, ERR_ZERO);
    runCase("negzero_sum",   32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, ERR_ZERO);
    runCase("poszero_mixed", 32'h0000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, ERR_ZERO);
    runCase("inf_minus_inf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, ERR_NAN);
    runCase("inf_sub_neginf",32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000, ERR_INF);
    runCase("nan_input",     32'h7F80_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, ERR_NAN);
    runCase("overflow",      32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, ERR_INF);
    runCase("tie_even",      32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, ERR_NONE);
    runCase("tie_round_up",  32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, ERR_NONE);
    runCase("x_plus_zero",   32'h1234_5678, 32'h8000_0000, 1'b0, 32'h1234_5678, ERR_NONE);
    runCase("cancel",        32'h3F80_0000, 32'hBF7F_FFFF, 1'b0, 32'h3380_0000, ERR_NONE);
`ifdef FP_ADD_FTZ_EN
    runCase("denorm_sum",    32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0000, ERR_ZERO);
    runCase("minnorm_sub",   32'h0080_0000, 32'h0000_0001, 1'b1, 32'h0080_0000, ERR_NONE);
`else
    runCase("denorm_sum",    32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002, ERR_DENORM);
    runCase("minnorm_sub",   32'h0080_0000, 32'h0000_0001, 1'b1, 32'h007F_FFFF, ERR_DENORM);
`endif

    // Asynchronous reset between edges clears the output immediately.
    applyStimulus(32'h4000_0000, 32'h4000_0000, 1'b0);
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checkOutput("async_reset", 32'h0, ERR_NONE);
    @(posedge clk);
    #1;
    checkOutput("reset_held", 32'h0, ERR_NONE);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("after_reset", 32'h4080_0000, ERR_NONE);

    for (int n = 0; n < 400; n++) begin
      ra  = rand_operand();
      rb  = rand_operand();
      rop = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        e = int'(ra[30:23]) + int'($urandom_range(0, 4)) - 2;
        if (e < 0)   e = 0;
        if (e > 254) e = 254;
        rb[30:23] = 8'(e);
      end
      rexp = ref_add(ra, rb, rop);
      runCase($sformatf("rand%0d_%h_%s_%h", n, ra, rop ? "sub" : "add", rb),
              ra, rb, rop, rexp, classify(rexp));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
